// File: rtl/rf_write_port.sv
// Integer register file write side: a 2-entry in-order writeback buffer,
// a one-hot commit decoder into 31 architectural registers (x0 hard-wired
// to zero), and a pending-write scoreboard for RAW hazard detection.
module rf_write_port #(
    parameter int XLEN       = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wb_valid,
    output logic               wb_ready,
    input  logic [4:0]         wb_rd,
    input  logic [XLEN-1:0]    wb_data,
    input  logic               commit_en,
    input  logic               iss_valid,
    input  logic [4:0]         iss_rd,
    output logic [32*XLEN-1:0] regs_flat,
    output logic [31:0]        pending,
    output logic [1:0]         fifo_cnt
);

    // Handshake: a writeback transfers on a rising edge where wb_valid and
    // wb_ready are both high. wb_ready depends only on fifo_cnt, so a pop in
    // the same cycle never opens a slot for a full buffer.

    // Buffer storage; slot 0 is always the head.
    logic [4:0]      q_rd   [0:1];
    logic [XLEN-1:0] q_data [0:1];

    logic            accept;
    logic            bypass;
    logic            pop;
    logic            enq;
    logic            commit_valid;
    logic [4:0]      commit_rd;
    logic [XLEN-1:0] commit_data;
    logic [31:0]     we;
    logic [31:0]     set_vec;
    logic [XLEN-1:0] regs_q [1:31];

    assign wb_ready = (fifo_cnt != 2'(FIFO_DEPTH));
    assign accept   = wb_valid & wb_ready;
    // An empty buffer lets the incoming write go straight to the registers.
    assign bypass   = (fifo_cnt == 2'd0) & commit_en & accept;
    assign pop      = (fifo_cnt != 2'd0) & commit_en;
    assign enq      = accept & ~bypass;

    // Select the commit source and decode it to a one-hot write enable.
    always_comb begin
        commit_valid = bypass | pop;
        commit_rd    = bypass ? wb_rd   : q_rd[0];
        commit_data  = bypass ? wb_data : q_data[0];
        we           = '0;
        if (commit_valid) begin
            we = (32'(1) << commit_rd) & ~32'(1);
        end
    end

    // Issue-side scoreboard set vector; x0 is never tracked.
    always_comb begin
        set_vec = '0;
        if (iss_valid) begin
            set_vec = (32'(1) << iss_rd) & ~32'(1);
        end
    end

    // Writeback buffer: shift on pop, fill at the tail on enqueue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_cnt  <= '0;
            q_rd[0]   <= '0;
            q_rd[1]   <= '0;
            q_data[0] <= '0;
            q_data[1] <= '0;
        end else begin
            if (pop && enq) begin
                // Only reachable with one entry, so the new write becomes head.
                q_rd[0]   <= wb_rd;
                q_data[0] <= wb_data;
            end else if (pop) begin
                q_rd[0]   <= q_rd[1];
                q_data[0] <= q_data[1];
                fifo_cnt  <= fifo_cnt - 2'd1;
            end else if (enq) begin
                q_rd[fifo_cnt[0]]   <= wb_rd;
                q_data[fifo_cnt[0]] <= wb_data;
                fifo_cnt            <= fifo_cnt + 2'd1;
            end
        end
    end

    // Architectural registers x1..x31, written by the one-hot decoder.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 1; i < 32; i++) begin
                if (we[i]) begin
                    regs_q[i] <= commit_data;
                end
            end
        end
    end

    // Pending scoreboard: a new issue outranks a same-edge commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            pending <= set_vec | (pending & ~we);
        end
    end

    // Flatten the register array for the read-select muxes; x0 reads zero.
    assign regs_flat[XLEN-1:0] = '0;
    for (genvar g = 1; g < 32; g++) begin : g_flat
        assign regs_flat[XLEN*g +: XLEN] = regs_q[g];
    end

endmodule

// File: tb/tb_rf_write_port.sv
// Directed bench for rf_write_port: bypass commit, buffered in-order
// drain, full-buffer backpressure, x0 handling, scoreboard priority and
// asynchronous reset in the middle of a drain.
module tb_rf_write_port;

    localparam int XLEN = 32;

    logic               clk;
    logic               rst_n;
    logic               wb_valid;
    logic               wb_ready;
    logic [4:0]         wb_rd;
    logic [XLEN-1:0]    wb_data;
    logic               commit_en;
    logic               iss_valid;
    logic [4:0]         iss_rd;
    logic [32*XLEN-1:0] regs_flat;
    logic [31:0]        pending;
    logic [1:0]         fifo_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    rf_write_port #(.XLEN(XLEN), .FIFO_DEPTH(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wb_valid  (wb_valid),
        .wb_ready  (wb_ready),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .commit_en (commit_en),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .regs_flat (regs_flat),
        .pending   (pending),
        .fifo_cnt  (fifo_cnt)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value.
    task automatic check(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [XLEN-1:0] reg_val(input int i);
        return regs_flat[XLEN*i +: XLEN];
    endfunction

    // Advance past the next rising edge and settle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_wb(input logic v, input logic [4:0] rd, input logic [XLEN-1:0] d);
        wb_valid = v;
        wb_rd    = rd;
        wb_data  = d;
    endtask

    initial begin
        rst_n     = 1'b0;
        commit_en = 1'b0;
        iss_valid = 1'b0;
        iss_rd    = '0;
        drive_wb(1'b0, 5'd0, '0);

        // Reset state
        #1;
        check("rst_cnt",     fifo_cnt, 2'd0);
        check("rst_ready",   wb_ready, 1'b1);
        check("rst_pending", pending, 32'h0);
        check("rst_regs",    regs_flat, '0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Bypass commit into an empty buffer
        commit_en = 1'b1;
        drive_wb(1'b1, 5'd5, 32'hDEADBEEF);
        #1;
        check("byp_ready_pre", wb_ready, 1'b1);
        step();
        drive_wb(1'b0, 5'd0, '0);
        check("byp_reg5",  regs_flat[191:160], 32'hDEADBEEF);
        check("byp_cnt",   fifo_cnt, 2'd0);
        check("byp_ready", wb_ready, 1'b1);

        // Fill the buffer with commits frozen
        commit_en = 1'b0;
        drive_wb(1'b1, 5'd1, 32'h11);
        step();
        check("fill_cnt1", fifo_cnt, 2'd1);
        check("fill_reg1_held", reg_val(1), 32'h0);
        drive_wb(1'b1, 5'd2, 32'h22);
        step();
        check("fill_cnt2",  fifo_cnt, 2'd2);
        check("fill_ready", wb_ready, 1'b0);
        // Third push while full, with a pop on the same edge: refused
        drive_wb(1'b1, 5'd3, 32'h33);
        commit_en = 1'b1;
        step();
        drive_wb(1'b0, 5'd0, '0);
        check("drain_reg1", reg_val(1), 32'h11);
        check("drain_cnt1", fifo_cnt, 2'd1);
        check("drain_reg2_wait", reg_val(2), 32'h0);
        step();
        check("drain_reg2", reg_val(2), 32'h22);
        check("drain_cnt0", fifo_cnt, 2'd0);
        step();
        check("drain_reg3", reg_val(3), 32'h0);

        // Write to x0 is accepted but changes nothing
        drive_wb(1'b1, 5'd0, 32'hFFFFFFFF);
        #1;
        check("x0_ready", wb_ready, 1'b1);
        step();
        drive_wb(1'b0, 5'd0, '0);
        check("x0_reg", regs_flat[31:0], 32'h0);
        check("x0_pend", pending[0], 1'b0);
        check("x0_cnt",  fifo_cnt, 2'd0);

        // Scoreboard: set, same-edge set+clear, clear
        iss_valid = 1'b1;
        iss_rd    = 5'd7;
        step();
        check("sb_set7", pending, 32'h0000_0080);
        drive_wb(1'b1, 5'd7, 32'h77);
        step();
        check("sb_setwins", pending[7], 1'b1);
        check("sb_reg7a", reg_val(7), 32'h77);
        iss_valid = 1'b0;
        drive_wb(1'b1, 5'd7, 32'h78);
        step();
        drive_wb(1'b0, 5'd0, '0);
        check("sb_clr7", pending[7], 1'b0);
        check("sb_reg7b", reg_val(7), 32'h78);
        // Set and clear on different indices in the same cycle
        iss_valid = 1'b1;
        iss_rd    = 5'd8;
        step();
        iss_rd = 5'd9;
        drive_wb(1'b1, 5'd8, 32'h88);
        step();
        drive_wb(1'b0, 5'd0, '0);
        check("sb_diff", pending, 32'h0000_0200);
        // Issue to x0 is never tracked; commit of 9 clears it
        iss_rd = 5'd0;
        drive_wb(1'b1, 5'd9, 32'h99);
        step();
        iss_valid = 1'b0;
        drive_wb(1'b0, 5'd0, '0);
        check("sb_x0", pending, 32'h0);

        // Same-rd writes drain in order
        commit_en = 1'b0;
        drive_wb(1'b1, 5'd4, 32'hA);
        step();
        drive_wb(1'b1, 5'd4, 32'hB);
        step();
        drive_wb(1'b0, 5'd0, '0);
        check("ord_cnt2", fifo_cnt, 2'd2);
        commit_en = 1'b1;
        step();
        check("ord_reg4a", reg_val(4), 32'hA);
        step();
        check("ord_reg4b", reg_val(4), 32'hB);
        check("ord_cnt0",  fifo_cnt, 2'd0);

        // Simultaneous pop and enqueue with one entry buffered
        commit_en = 1'b0;
        drive_wb(1'b1, 5'd12, 32'hC12);
        step();
        commit_en = 1'b1;
        drive_wb(1'b1, 5'd13, 32'hC13);
        step();
        drive_wb(1'b0, 5'd0, '0);
        check("pe_reg12", reg_val(12), 32'hC12);
        check("pe_cnt",   fifo_cnt, 2'd1);
        check("pe_reg13_wait", reg_val(13), 32'h0);
        step();
        check("pe_reg13", reg_val(13), 32'hC13);
        check("pe_cnt0",  fifo_cnt, 2'd0);

        // Asynchronous reset in the middle of a drain
        commit_en = 1'b0;
        iss_valid = 1'b1;
        iss_rd    = 5'd20;
        drive_wb(1'b1, 5'd10, 32'h1010);
        step();
        iss_valid = 1'b0;
        drive_wb(1'b1, 5'd11, 32'h1111);
        step();
        drive_wb(1'b0, 5'd0, '0);
        commit_en = 1'b1;
        step();
        check("mid_reg10", reg_val(10), 32'h1010);
        check("mid_cnt1",  fifo_cnt, 2'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_regs",    regs_flat, '0);
        check("arst_pending", pending, 32'h0);
        check("arst_cnt",     fifo_cnt, 2'd0);
        check("arst_ready",   wb_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        step();
        check("arst_discard", reg_val(11), 32'h0);
        check("arst_cnt_after", fifo_cnt, 2'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
